ppu_mem_loader: RTL and testbench

//  Consumer of (address, value) preload pairs for the PPU memories: accepts a valid/ready pair stream,

---
 rtl/ppu_loader_pkg.sv | 39 +++
 rtl/ppu_mem_loader.sv | 175 +++++++++++++++++
 tb/tb_ppu_mem_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_loader_pkg.sv
// Shared types and helpers for the PPU memory preload loader.
`timescale 1ns/1ps
package ppu_loader_pkg;

  localparam int VRAM_AW = 14;
  localparam int OAM_AW  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    READ,
    WAIT,
    CMP,
    FINISH
  } ldr_state_t;

  typedef enum logic {
    TGT_VRAM,
    TGT_OAM
  } ldr_target_t;

  // Saturating increment for the 16-bit write counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating increment for the 8-bit error counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A pair is only legal if its address fits the selected memory without wrapping.
  function automatic logic addr_in_range(input logic tgt, input logic [15:0] a);
    if (tgt == TGT_OAM) return (a[15:OAM_AW] == '0);
    else                return (a[15:VRAM_AW] == '0);
  endfunction

endpackage

// File: rtl/ppu_mem_loader.sv
// Consumes (address, value) preload pairs and writes them into PPU VRAM or OAM,
// optionally reading each location back to verify it, and reports progress/errors.
`timescale 1ns/1ps
module ppu_mem_loader #(
  parameter int RD_LATENCY = 1,
  parameter int VERIFY_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pair_valid,
  output logic        pair_ready,
  input  logic        pair_target,
  input  logic [15:0] pair_addr,
  input  logic [7:0]  pair_data,
  input  logic        pair_last,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        vram_re,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        oam_re,
  input  logic [7:0]  oam_rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] wr_count,
  output logic [7:0]  err_count,
  output logic [15:0] first_err_addr
);

  import ppu_loader_pkg::*;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_ACCEPT = ACCEPT;
  localparam logic [2:0] ST_WRITE  = WRITE;
  localparam logic [2:0] ST_READ   = READ;
  localparam logic [2:0] ST_WAIT   = WAIT;
  localparam logic [2:0] ST_CMP    = CMP;
  localparam logic [2:0] ST_FINISH = FINISH;

  logic [2:0]  state;
  logic [1:0]  wait_cnt;
  ldr_target_t tgt_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        last_q;

  logic        handshake;
  logic        in_range;
  logic        arm;
  logic [7:0]  rdata_sel;
  logic        mismatch;
  logic        range_err;
  logic        new_err;
  logic [15:0] err_addr;

  assign busy       = (state != ST_IDLE) && (state != ST_FINISH);
  assign pair_ready = busy && (state == ST_ACCEPT);
  assign done       = (state == ST_FINISH);
  assign handshake  = pair_valid && pair_ready;
  assign in_range   = addr_in_range(pair_target, pair_addr);
  assign arm        = start && !busy;

  assign vram_we = (state == ST_WRITE) && (tgt_q == TGT_VRAM);
  assign oam_we  = (state == ST_WRITE) && (tgt_q == TGT_OAM);
  assign vram_re = (state == ST_READ)  && (tgt_q == TGT_VRAM);
  assign oam_re  = (state == ST_READ)  && (tgt_q == TGT_OAM);

  assign rdata_sel = (tgt_q == TGT_OAM) ? oam_rdata : vram_rdata;
  assign mismatch  = (state == ST_CMP) && (rdata_sel != data_q);
  assign range_err = handshake && !in_range;
  assign new_err   = mismatch || range_err;
  assign err_addr  = range_err ? pair_addr : addr_q;

  // Sequence each pair through write, optional readback, and the compare cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) state <= ST_ACCEPT;
        end
        ST_ACCEPT: begin
          if (handshake) begin
            if (in_range)       state <= ST_WRITE;
            else if (pair_last) state <= ST_FINISH;
            else                state <= ST_ACCEPT;
          end
        end
        ST_WRITE: begin
          if (VERIFY_EN != 0) state <= ST_READ;
          else if (last_q)    state <= ST_FINISH;
          else                state <= ST_ACCEPT;
        end
        ST_READ: begin
          if (RD_LATENCY > 1) begin
            state    <= ST_WAIT;
            wait_cnt <= 2'(RD_LATENCY - 2);
          end else begin
            state <= ST_CMP;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) state <= ST_CMP;
          else                  wait_cnt <= wait_cnt - 2'd1;
        end
        ST_CMP: begin
          state <= last_q ? ST_FINISH : ST_ACCEPT;
        end
        ST_FINISH: begin
          state <= arm ? ST_ACCEPT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the accepted pair so it stays stable for the write/readback cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q  <= TGT_VRAM;
      addr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (handshake) begin
      tgt_q  <= ldr_target_t'(pair_target);
      addr_q <= pair_addr;
      data_q <= pair_data;
      last_q <= pair_last;
    end
  end

  // Memory address/data ports only move for legal pairs aimed at them, otherwise they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      vram_addr  <= '0;
      vram_wdata <= '0;
      oam_addr   <= '0;
      oam_wdata  <= '0;
    end else if (handshake && in_range) begin
      if (pair_target == TGT_OAM) begin
        oam_addr  <= pair_addr[OAM_AW-1:0];
        oam_wdata <= pair_data;
      end else begin
        vram_addr  <= pair_addr[VRAM_AW-1:0];
        vram_wdata <= pair_data;
      end
    end
  end

  // Progress and error bookkeeping; a fresh start wipes the previous listing's results.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (arm) begin
      wr_count       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (state == ST_WRITE) wr_count <= sat_inc16(wr_count);
      if (new_err) begin
        err_count <= sat_inc8(err_count);
        if (err_count == 8'd0) first_err_addr <= err_addr;
      end
    end
  end

endmodule

// File: tb/tb_ppu_mem_loader.sv
// Directed, table-driven bench for ppu_mem_loader with behavioural VRAM/OAM models.
`timescale 1ns/1ps
module tb_ppu_mem_loader;

  localparam int RD_LATENCY = 2;
  localparam int PAIR_CYCLES = 3 + RD_LATENCY;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pair_valid = 1'b0;
  logic        pair_ready;
  logic        pair_target = 1'b0;
  logic [15:0] pair_addr = '0;
  logic [7:0]  pair_data = '0;
  logic        pair_last = 1'b0;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        vram_re;
  logic [7:0]  vram_rdata = '0;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        oam_re;
  logic [7:0]  oam_rdata = '0;
  logic        busy;
  logic        done;
  logic [15:0] wr_count;
  logic [7:0]  err_count;
  logic [15:0] first_err_addr;

  ppu_mem_loader #(.RD_LATENCY(RD_LATENCY), .VERIFY_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_target(pair_target),
    .pair_addr(pair_addr), .pair_data(pair_data), .pair_last(pair_last),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .vram_re(vram_re), .vram_rdata(vram_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .oam_re(oam_re), .oam_rdata(oam_rdata),
    .busy(busy), .done(done), .wr_count(wr_count), .err_count(err_count),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // Memory models with RD_LATENCY-cycle read pipeline; VRAM readback can be forced to 00.
  logic [7:0] vram_mem [0:16383];
  logic [7:0] oam_mem  [0:255];
  logic [7:0] vram_pipe = '0;
  logic [7:0] oam_pipe  = '0;
  logic       vram_stuck = 1'b0;

  always @(posedge clk) begin
    if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    if (oam_we)  oam_mem[oam_addr]   <= oam_wdata;
    if (vram_re) vram_pipe <= vram_stuck ? 8'h00 : vram_mem[vram_addr];
    if (oam_re)  oam_pipe  <= oam_mem[oam_addr];
    vram_rdata <= vram_pipe;
    oam_rdata  <= oam_pipe;
  end

  // Strobe/done monitor sampled on the falling edge.
  int vwe_cnt = 0, owe_cnt = 0, vre_cnt = 0, ore_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  logic [13:0] strobe_vaddr = '0;
  logic [7:0]  strobe_vdata = '0, strobe_oaddr = '0, strobe_odata = '0;

  always @(negedge clk) begin
    if (vram_we) begin vwe_cnt++; strobe_vaddr = vram_addr; strobe_vdata = vram_wdata; end
    if (oam_we)  begin owe_cnt++; strobe_oaddr = oam_addr;  strobe_odata = oam_wdata;  end
    if (vram_re) vre_cnt++;
    if (oam_re)  ore_cnt++;
    if ((vram_we || vram_re) && (oam_we || oam_re)) overlap_cnt++;
    if (done) done_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int done_base = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Arm the loader and confirm the counters come back cleared.
  task automatic start_listing();
    @(negedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    check_output("start_busy", 32'(busy), 32'd1);
    check_output("start_ready", 32'(pair_ready), 32'd1);
    check_output("start_wr_clr", 32'(wr_count), 32'd0);
    check_output("start_err_clr", 32'(err_count), 32'd0);
    check_output("start_first_clr", 32'(first_err_addr), 32'd0);
    done_base = done_cnt;
  endtask

  // Offer one pair, complete the handshake and wait until the loader is ready again or finishes.
  task automatic apply_stimulus(input logic tgt, input logic [15:0] addr, input logic [7:0] data,
                                input logic last, output int cycles);
    int w;
    w = 0;
    while (!pair_ready && w < 30) begin @(negedge clk); #1; w++; end
    check_output("ready_before_pair", 32'(pair_ready), 32'd1);
    pair_valid  = 1'b1;
    pair_target = tgt;
    pair_addr   = addr;
    pair_data   = data;
    pair_last   = last;
    @(posedge clk); #1;
    pair_valid = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk); #1;
      cycles++;
    end while (!(pair_ready || done) && cycles < 30);
  endtask

  typedef struct {
    logic        tgt;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        last;
    logic        stuck;
    int          exp_vwe;
    int          exp_owe;
    logic [15:0] exp_wr;
    logic [7:0]  exp_err;
    logic [15:0] exp_first;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_vec(logic tgt, logic [15:0] addr, logic [7:0] data, logic last,
                                  logic stuck, int vwe, int owe, logic [15:0] wr,
                                  logic [7:0] err, logic [15:0] first);
    vec_t v;
    v.tgt = tgt; v.addr = addr; v.data = data; v.last = last; v.stuck = stuck;
    v.exp_vwe = vwe; v.exp_owe = owe; v.exp_wr = wr; v.exp_err = err; v.exp_first = first;
    tbl.push_back(v);
  endfunction

  initial begin
    int cyc;
    int base_vwe, base_owe, base_vre, base_ore;
    int stall_bad;
    logic [13:0] exp_vaddr;
    logic [7:0]  exp_vdata, exp_oaddr, exp_odata;

    //        tgt  addr      data   last  stuck vwe owe wr        err    first
    add_vec(1'b0, 16'h0000, 8'hFF, 1'b0, 1'b0, 1, 0, 16'd1, 8'd0, 16'h0000);
    add_vec(1'b0, 16'h0001, 8'h00, 1'b1, 1'b0, 1, 0, 16'd2, 8'd0, 16'h0000);
    add_vec(1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 0, 1, 16'd1, 8'd0, 16'h0000);
    add_vec(1'b1, 16'h0001, 8'h00, 1'b0, 1'b0, 0, 1, 16'd2, 8'd0, 16'h0000);
    add_vec(1'b1, 16'h0002, 8'h1F, 1'b0, 1'b0, 0, 1, 16'd3, 8'd0, 16'h0000);
    add_vec(1'b1, 16'h0003, 8'h00, 1'b1, 1'b0, 0, 1, 16'd4, 8'd0, 16'h0000);
    add_vec(1'b0, 16'h4000, 8'hAA, 1'b0, 1'b0, 0, 0, 16'd0, 8'd1, 16'h4000);
    add_vec(1'b1, 16'h0100, 8'h55, 1'b1, 1'b0, 0, 0, 16'd0, 8'd2, 16'h4000);
    add_vec(1'b0, 16'h3FFF, 8'h5A, 1'b0, 1'b0, 1, 0, 16'd1, 8'd0, 16'h0000);
    add_vec(1'b1, 16'h00FF, 8'hA5, 1'b1, 1'b0, 0, 1, 16'd2, 8'd0, 16'h0000);
    add_vec(1'b0, 16'h23C0, 8'h0D, 1'b0, 1'b1, 1, 0, 16'd1, 8'd1, 16'h23C0);
    add_vec(1'b0, 16'h23C1, 8'h00, 1'b0, 1'b1, 1, 0, 16'd2, 8'd1, 16'h23C0);
    add_vec(1'b0, 16'h23C2, 8'h11, 1'b1, 1'b1, 1, 0, 16'd3, 8'd2, 16'h23C0);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_ready", 32'(pair_ready), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_strobes", 32'({vram_we, vram_re, oam_we, oam_re}), 32'd0);
    check_output("rst_counts", 32'({wr_count, err_count}), 32'd0);
    check_output("rst_first", 32'(first_err_addr), 32'd0);
    check_output("rst_addrs", 32'({vram_addr, oam_addr}), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check_output("idle_busy", 32'(busy), 32'd0);

    // Table-driven listings.
    exp_vaddr = '0; exp_vdata = '0; exp_oaddr = '0; exp_odata = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 0 || tbl[i-1].last) start_listing();
      vram_stuck = tbl[i].stuck;
      base_vwe = vwe_cnt; base_owe = owe_cnt; base_vre = vre_cnt; base_ore = ore_cnt;
      apply_stimulus(tbl[i].tgt, tbl[i].addr, tbl[i].data, tbl[i].last, cyc);
      if (tbl[i].exp_vwe != 0) begin
        exp_vaddr = tbl[i].addr[13:0]; exp_vdata = tbl[i].data;
        check_output("vwe_addr", 32'(strobe_vaddr), 32'(exp_vaddr));
        check_output("vwe_data", 32'(strobe_vdata), 32'(exp_vdata));
      end
      if (tbl[i].exp_owe != 0) begin
        exp_oaddr = tbl[i].addr[7:0]; exp_odata = tbl[i].data;
        check_output("owe_addr", 32'(strobe_oaddr), 32'(exp_oaddr));
        check_output("owe_data", 32'(strobe_odata), 32'(exp_odata));
      end
      check_output("vram_we_pulses", 32'(vwe_cnt - base_vwe), 32'(tbl[i].exp_vwe));
      check_output("oam_we_pulses", 32'(owe_cnt - base_owe), 32'(tbl[i].exp_owe));
      check_output("vram_re_pulses", 32'(vre_cnt - base_vre), 32'(tbl[i].exp_vwe));
      check_output("oam_re_pulses", 32'(ore_cnt - base_ore), 32'(tbl[i].exp_owe));
      check_output("pair_cycles", 32'(cyc),
                   (tbl[i].exp_vwe + tbl[i].exp_owe != 0) ? 32'(PAIR_CYCLES) : 32'd1);
      check_output("wr_count", 32'(wr_count), 32'(tbl[i].exp_wr));
      check_output("err_count", 32'(err_count), 32'(tbl[i].exp_err));
      check_output("first_err_addr", 32'(first_err_addr), 32'(tbl[i].exp_first));
      check_output("vram_addr_hold", 32'({vram_addr, vram_wdata}), 32'({exp_vaddr, exp_vdata}));
      check_output("oam_addr_hold", 32'({oam_addr, oam_wdata}), 32'({exp_oaddr, exp_odata}));
      if (tbl[i].last) begin
        check_output("done_pulse", 32'(done_cnt - done_base), 32'd1);
        @(negedge clk); #1;
        check_output("done_one_cycle", 32'({done, busy}), 32'd0);
      end
    end
    vram_stuck = 1'b0;
    check_output("oam_mem_02", 32'(oam_mem[2]), 32'h1F);
    check_output("vram_mem_0000", 32'(vram_mem[0]), 32'hFF);
    check_output("vram_mem_3fff", 32'(vram_mem[16383]), 32'h5A);

    // pair_valid held low mid-listing.
    start_listing();
    apply_stimulus(1'b0, 16'h0100, 8'h3C, 1'b0, cyc);
    base_vwe = vwe_cnt; base_owe = owe_cnt; base_vre = vre_cnt; base_ore = ore_cnt;
    stall_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (!pair_ready || !busy) stall_bad++;
    end
    check_output("stall_ready_busy", 32'(stall_bad), 32'd0);
    check_output("stall_strobes",
                 32'((vwe_cnt - base_vwe) + (owe_cnt - base_owe) + (vre_cnt - base_vre) + (ore_cnt - base_ore)),
                 32'd0);
    apply_stimulus(1'b0, 16'h0101, 8'hC3, 1'b1, cyc);
    check_output("stall_wr_count", 32'(wr_count), 32'd2);
    check_output("stall_err_count", 32'(err_count), 32'd0);
    check_output("stall_done", 32'(done_cnt - done_base), 32'd1);
    check_output("stall_mem", 32'(vram_mem[14'h0101]), 32'hC3);

    // start ignored while busy, then reset during the readback wait.
    start_listing();
    apply_stimulus(1'b0, 16'h0010, 8'h77, 1'b0, cyc);
    check_output("busy_start_pre_wr", 32'(wr_count), 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    check_output("busy_start_ignored_busy", 32'(busy), 32'd1);
    check_output("busy_start_ignored_wr", 32'(wr_count), 32'd1);
    check_output("busy_start_ready", 32'(pair_ready), 32'd1);
    pair_valid = 1'b1; pair_target = 1'b0; pair_addr = 16'h0011; pair_data = 8'h88; pair_last = 1'b0;
    @(posedge clk); #1;
    pair_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_output("abort_busy_ready_done", 32'({busy, pair_ready, done}), 32'd0);
    check_output("abort_strobes", 32'({vram_we, vram_re, oam_we, oam_re}), 32'd0);
    check_output("abort_counts", 32'({wr_count, err_count}), 32'd0);
    check_output("abort_first", 32'(first_err_addr), 32'd0);
    check_output("abort_addrs", 32'({vram_addr, vram_wdata}), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check_output("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    start_listing();
    apply_stimulus(1'b0, 16'h0012, 8'h99, 1'b1, cyc);
    check_output("rearm_cycles", 32'(cyc), 32'(PAIR_CYCLES));
    check_output("rearm_wr_count", 32'(wr_count), 32'd1);
    check_output("rearm_err_count", 32'(err_count), 32'd0);
    check_output("rearm_done", 32'(done_cnt - done_base), 32'd1);

    check_output("strobe_overlap", 32'(overlap_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
